// File: rtl/base_fifo_pr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : base_fifo_pr_if                                            |
// | Brief   : Bus-strobe access and status bundle for base_fifo_pr.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface base_fifo_pr_if #(
  parameter int DW = 8,
  parameter int AW = 11
);
  logic          wr;
  logic [DW-1:0] din;
  logic          rd;
  logic [DW-1:0] dout;
  logic          flush;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          afull;
  logic          aempty;
  logic          err_clr;
  logic          ovf;
  logic          udf;

  modport master (
    output wr, din, rd, flush, err_clr,
    input  dout, empty, full, level, afull, aempty, ovf, udf
  );

  modport slave (
    input  wr, din, rd, flush, err_clr,
    output dout, empty, full, level, afull, aempty, ovf, udf
  );
endinterface
`default_nettype wire

// File: rtl/base_fifo_pr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : base_fifo_pr                                               |
// | Brief   : Single-clock mailbox FIFO; accesses are wr/rd windows      |
// |           committed on the window's falling edge.                    |
// |           Optional sticky ovf/udf flags: define FIFO_ERR_EN.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module base_fifo_pr #(
  parameter int DW     = 8,
  parameter int AW     = 11,
  parameter int AF_LVL = 2**AW - 16,
  parameter int AE_LVL = 16
) (
  input  wire logic         clk,
  input  wire logic         sys_rst_n,
  base_fifo_pr_if.slave     bus
);

  localparam int          c_depth_i = 2**AW;
  localparam logic [AW:0] c_depth   = c_depth_i[AW:0];
  localparam logic [AW:0] c_af      = AF_LVL[AW:0];
  localparam logic [AW:0] c_ae      = AE_LVL[AW:0];
  localparam logic [AW:0] c_one     = 1;

  logic [DW-1:0] r_mem [c_depth_i];

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_level;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_dout;
  logic          r_wr_q;
  logic          r_rd_q;
  logic          r_rd_arm;
  logic          r_wr_ok;
  logic          r_rd_ok;
  logic          r_run;

  logic w_empty;
  logic w_full;
  logic w_wr_rise;
  logic w_rd_rise;
  logic w_push_evt;
  logic w_pop_evt;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_depth);

  // A window only counts if its rising edge was seen outside reset/flush;
  // r_run masks the first clock after reset, r_*_ok is cleared by flush.
  assign w_wr_rise  = bus.wr & ~r_wr_q & r_run;
  assign w_rd_rise  = bus.rd & ~r_rd_q & r_run;
  assign w_push_evt = r_wr_q & ~bus.wr & r_wr_ok;
  assign w_pop_evt  = r_rd_q & ~bus.rd & r_rd_ok;
  assign w_pop_ok   = w_pop_evt & r_rd_arm & ~w_empty;
  assign w_push_ok  = w_push_evt & (~w_full | w_pop_ok);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_hold   <= '0;
      r_dout   <= '0;
      r_wr_q   <= 1'b0;
      r_rd_q   <= 1'b0;
      r_rd_arm <= 1'b0;
      r_wr_ok  <= 1'b0;
      r_rd_ok  <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_wr_q <= bus.wr;
      r_rd_q <= bus.rd;
      r_dout <= r_mem[r_rd_ptr[AW-1:0]];
      if (bus.wr) begin
        r_hold <= bus.din;
      end
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_rd_arm <= 1'b0;
        r_wr_ok  <= 1'b0;
        r_rd_ok  <= 1'b0;
      end else begin
        if (w_wr_rise) begin
          r_wr_ok <= 1'b1;
        end
        if (w_rd_rise) begin
          r_rd_ok  <= 1'b1;
          r_rd_arm <= ~w_empty;
        end
        if (w_push_ok) begin
          r_wr_ptr <= r_wr_ptr + c_one;
        end
        if (w_pop_ok) begin
          r_rd_ptr <= r_rd_ptr + c_one;
        end
        case ({w_push_ok, w_pop_ok})
          2'b10:   r_level <= r_level + c_one;
          2'b01:   r_level <= r_level - c_one;
          default: r_level <= r_level;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !bus.flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_hold;
    end
  end

  assign bus.dout   = r_dout;
  assign bus.empty  = w_empty;
  assign bus.full   = w_full;
  assign bus.level  = r_level;
  assign bus.afull  = (r_level >= c_af);
  assign bus.aempty = (r_level <= c_ae);

`ifdef FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = w_push_evt & ~w_push_ok & ~bus.flush;
  assign w_udf_set = w_pop_evt & ~w_pop_ok & ~bus.flush;

  // A new error on the err_clr edge keeps the flag set.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr);
      r_udf <= w_udf_set | (r_udf & ~bus.err_clr);
    end
  end

  assign bus.ovf = r_ovf;
  assign bus.udf = r_udf;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = bus.err_clr;
  assign bus.ovf          = 1'b0;
  assign bus.udf          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_base_fifo_pr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_base_fifo_pr                                            |
// | Brief   : Scoreboard bench for base_fifo_pr (AW=4, AF=14, AE=2).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_base_fifo_pr;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 clk = ~clk;

  base_fifo_pr_if #(.DW(DW), .AW(AW)) bus ();

  base_fifo_pr #(.DW(DW), .AW(AW), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] dut_stat();
    return {bus.empty, bus.full, bus.aempty, bus.afull, bus.ovf, bus.udf, bus.level};
  endfunction

  function automatic logic [10:0] mdl_stat();
    int          lv;
    logic [AW:0] l;
    lv = q.size();
    l  = lv[AW:0];
    return {lv == 0, lv == DEPTH, lv <= AE, lv >= AF, m_ovf, m_udf, l};
  endfunction

  task automatic write_win(input logic [DW-1:0] d, input int n);
    bus.wr  = 1'b1;
    bus.din = d;
    repeat (n) tick();
    bus.wr  = 1'b0;
    bus.din = '0;
    tick();
    if (q.size() < DEPTH) q.push_back(d);
    else if (ERR_EN) m_ovf = 1'b1;
  endtask

  task automatic read_win(input int n, output logic [DW-1:0] seen);
    bus.rd = 1'b1;
    repeat (n) tick();
    seen   = bus.dout;
    bus.rd = 1'b0;
    tick();
    if (q.size() > 0) void'(q.pop_front());
    else if (ERR_EN) m_udf = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL reset_stat got=%h exp=%h", dut_stat(), mdl_stat());
    end
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout);
    end
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] seen, exp_d;
    write_win(8'h11, 4);
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL basic_first_push got=%h exp=%h", dut_stat(), mdl_stat());
    end
    tick();
    checks++;
    if (bus.dout !== 8'h11) begin
      failures++; $display("FAIL basic_first_dout got=%h exp=11", bus.dout);
    end
    write_win(8'h22, 4);
    write_win(8'h33, 4);
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL basic_lvl3 got=%h exp=%h", dut_stat(), mdl_stat());
    end
    for (int k = 0; k < 3; k++) begin
      exp_d = q[0];
      read_win(4, seen);
      checks++;
      if (seen !== exp_d) begin
        failures++; $display("FAIL basic_pop%0d got=%h exp=%h", k, seen, exp_d);
      end
      tick();
      if (q.size() > 0) begin
        checks++;
        if (bus.dout !== q[0]) begin
          failures++; $display("FAIL basic_head%0d got=%h exp=%h", k, bus.dout, q[0]);
        end
      end
      checks++;
      if (dut_stat() !== mdl_stat()) begin
        failures++; $display("FAIL basic_rd_stat%0d got=%h exp=%h", k, dut_stat(), mdl_stat());
      end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      write_win(8'(8'h40 + i), 1);
      checks++;
      if (dut_stat() !== mdl_stat()) begin
        failures++; $display("FAIL fill_stat%0d got=%h exp=%h", i, dut_stat(), mdl_stat());
      end
    end
    write_win(8'hEE, 1);
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL full_drop got=%h exp=%h", dut_stat(), mdl_stat());
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    m_ovf = 1'b0;
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL err_clr got=%h exp=%h", dut_stat(), mdl_stat());
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] seen, exp_d;
    bus.rd = 1'b1;
    tick();
    bus.wr  = 1'b1;
    bus.din = 8'hC5;
    repeat (2) tick();
    bus.rd  = 1'b0;
    bus.wr  = 1'b0;
    bus.din = '0;
    tick();
    void'(q.pop_front());
    q.push_back(8'hC5);
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL overlap_stat got=%h exp=%h", dut_stat(), mdl_stat());
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_d = q[0];
      read_win(2, seen);
      checks++;
      if (seen !== exp_d) begin
        failures++; $display("FAIL drain%0d got=%h exp=%h", i, seen, exp_d);
      end
    end
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL drain_stat got=%h exp=%h", dut_stat(), mdl_stat());
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] seen, exp_d;
    write_win(8'h00, 1);
    for (int i = 1; i <= 40; i++) begin
      if (i < 40) write_win(8'(i), 1);
      checks++;
      if (dut_stat() !== mdl_stat()) begin
        failures++; $display("FAIL wrap_stat%0d got=%h exp=%h", i, dut_stat(), mdl_stat());
      end
      exp_d = q[0];
      read_win(2, seen);
      checks++;
      if (seen !== exp_d) begin
        failures++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, seen, exp_d);
      end
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] seen;
    read_win(2, seen);
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL udf_stat got=%h exp=%h", dut_stat(), mdl_stat());
    end
    write_win(8'h5A, 1);
    read_win(2, seen);
    checks++;
    if (seen !== 8'h5A) begin
      failures++; $display("FAIL udf_rdptr got=%h exp=5a", seen);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    m_udf = 1'b0;
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL udf_clr got=%h exp=%h", dut_stat(), mdl_stat());
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] seen;
    for (int i = 0; i < 5; i++) write_win(8'(8'h60 + i), 1);
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL flush_pre got=%h exp=%h", dut_stat(), mdl_stat());
    end
    bus.wr  = 1'b1;
    bus.din = 8'hAA;
    repeat (2) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    q.delete();
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL flush_clear got=%h exp=%h", dut_stat(), mdl_stat());
    end
    tick();
    bus.wr  = 1'b0;
    bus.din = '0;
    tick();
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL flush_window got=%h exp=%h", dut_stat(), mdl_stat());
    end
    write_win(8'h3C, 1);
    read_win(2, seen);
    checks++;
    if (seen !== 8'h3C) begin
      failures++; $display("FAIL flush_reuse got=%h exp=3c", seen);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) write_win(8'(8'h90 + i), 1);
    bus.wr  = 1'b1;
    bus.din = 8'h77;
    tick();
    #2 sys_rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL rst_mid_stat got=%h exp=%h", dut_stat(), mdl_stat());
    end
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL rst_mid_dout got=%h exp=00", bus.dout);
    end
    repeat (2) tick();
    sys_rst_n = 1'b1;
    repeat (2) tick();
    bus.wr  = 1'b0;
    bus.din = '0;
    repeat (2) tick();
    checks++;
    if (dut_stat() !== mdl_stat()) begin
      failures++; $display("FAIL rst_window got=%h exp=%h", dut_stat(), mdl_stat());
    end
  endtask

  initial begin
    bus.wr      = 1'b0;
    bus.din     = '0;
    bus.rd      = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_wrap();
    test_underflow();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
